keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner for ROWS x COLS keypads. Drives one row high at a time and synchronises the column inputs. Debounces both press and release by counting cycles. Emits a one-cycle strobe with a linear key code, and optionally generates typematic auto-repeat while a key is held. Sits between the board pins and the display/entry logic, replacing the fixed 4x4, clock-per-row decoder.

---
 rtl/keypad_scanner.sv | 161 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot row drive, synchronised column sensing,
// press/release debounce, linear key code and optional typematic repeat.
module keypad_scanner #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DLY   = 500000,
  parameter int REPEAT_RATE  = 100000,
  localparam int CODE_W      = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COLS-1:0]   cols,
  output logic [ROWS-1:0]   rows,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              key_release,
  output logic              multi_key
);

  localparam int RIW = $clog2(ROWS);
  localparam int CIW = $clog2(COLS);
  localparam int DVW = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int RPW = $clog2(REPEAT_DLY);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;

  state_t          state;
  logic [COLS-1:0] cs_meta;
  logic [COLS-1:0] cs;
  logic [DVW-1:0]  dwell;
  logic [DBW-1:0]  deb_cnt;
  logic [RPW-1:0]  rep_cnt;
  logic [RIW-1:0]  row_idx;
  logic [RIW-1:0]  row_nxt;
  logic [CIW-1:0]  col_idx;
  logic [CIW-1:0]  low_col;
  logic            low_found;
  logic [3:0]      ones;
  logic            multi;
  logic            key_bit;

  // Two-flop synchroniser for the asynchronous column inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_meta <= '0;
      cs      <= '0;
    end else begin
      cs_meta <= cols;
      cs      <= cs_meta;
    end
  end

  // Lowest set column, more-than-one-column flag, and next row index
  always_comb begin
    low_col   = '0;
    low_found = 1'b0;
    ones      = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      ones = ones + 4'(cs[i]);
      if (cs[i] && !low_found) begin
        low_col   = CIW'(i);
        low_found = 1'b1;
      end
    end
    multi   = (ones > 4'd1);
    key_bit = cs[col_idx];
    row_nxt = (row_idx == RIW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
  end

  // Scan / debounce / hold state machine with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN;
      rows        <= ROWS'(1);
      row_idx     <= '0;
      col_idx     <= '0;
      dwell       <= '0;
      deb_cnt     <= '0;
      rep_cnt     <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell == DVW'(SCAN_DIV - 1)) begin
            dwell <= '0;
            if (|cs) begin
              col_idx   <= low_col;
              multi_key <= multi;
              deb_cnt   <= '0;
              state     <= DEB_PRESS;
            end else begin
              rows    <= {rows[ROWS-2:0], rows[ROWS-1]};
              row_idx <= row_nxt;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        DEB_PRESS: begin
          if (key_bit) begin
            if (deb_cnt == DBW'(DEBOUNCE_CYC)) begin
              key_code  <= CODE_W'(int'(row_idx) * COLS + int'(col_idx));
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              rep_cnt   <= '0;
              state     <= HELD;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            rows    <= {rows[ROWS-2:0], rows[ROWS-1]};
            row_idx <= row_nxt;
            state   <= SCAN;
          end
        end
        HELD: begin
          if (!key_bit) begin
            deb_cnt <= '0;
            state   <= DEB_RELEASE;
          end else if (REPEAT_EN != 0) begin
            // Reload instead of clearing so later repeats land every REPEAT_RATE
            if (rep_cnt == RPW'(REPEAT_DLY - 1)) begin
              key_valid <= 1'b1;
              rep_cnt   <= RPW'(REPEAT_DLY - REPEAT_RATE);
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
        end
        DEB_RELEASE: begin
          if (!key_bit) begin
            if (deb_cnt == DBW'(DEBOUNCE_CYC)) begin
              key_release <= 1'b1;
              key_held    <= 1'b0;
              rows        <= {rows[ROWS-2:0], rows[ROWS-1]};
              row_idx     <= row_nxt;
              state       <= SCAN;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            state <= HELD;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model driving cols
// from rows, behavioural reference model, per-cycle compare, directed tests.
module tb_keypad_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SD   = 4;
  localparam int DEB  = 8;
  localparam int DLY  = 40;
  localparam int RATE = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [COLS-1:0] cols;
  logic [ROWS-1:0] rows;
  logic [3:0]      key_code;
  logic            key_valid, key_held, key_release, multi_key;

  logic [ROWS*COLS-1:0] keys = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_valid = 0;
  int n_rel   = 0;
  int vq[$];

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE_CYC(DEB),
    .REPEAT_EN(1), .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .key_release(key_release), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key connects its row drive to its column
  always_comb begin
    cols = '0;
    for (int r = 0; r < ROWS; r++)
      if (rows[r]) cols = cols | keys[r*COLS +: COLS];
  end

  // Reference model state (behavioural, in terms of runs and elapsed time)
  localparam int M_SCAN = 0, M_PRESS = 1, M_HELD = 2, M_REL = 3;
  int m_mode, m_row, m_col, m_dwell, m_run, m_elapsed;
  int e_code;
  bit e_valid, e_held, e_rel, e_multi;
  logic [COLS-1:0] s1, s2;
  bit m_started = 0;

  always @(posedge clk) cyc++;

  // Reference model: advances once per clock edge
  always @(posedge clk) begin
    logic [COLS-1:0] cin;
    logic [COLS-1:0] csm;
    cin = keys[m_row*COLS +: COLS];
    m_started = 1;
    e_valid = 0;
    e_rel = 0;
    if (reset) begin
      m_mode = M_SCAN; m_row = 0; m_col = 0; m_dwell = 0; m_run = 0; m_elapsed = 0;
      e_code = 0; e_held = 0; e_multi = 0;
      s1 = '0; s2 = '0;
    end else begin
      csm = s2;
      case (m_mode)
        M_SCAN: begin
          m_dwell++;
          if (m_dwell == SD) begin
            m_dwell = 0;
            if (csm != 0) begin
              m_col = 0;
              while (!csm[m_col]) m_col++;
              e_multi = ($countones(csm) > 1);
              m_run = 0;
              m_mode = M_PRESS;
            end else m_row = (m_row + 1) % ROWS;
          end
        end
        M_PRESS: begin
          if (csm[m_col]) begin
            m_run++;
            if (m_run == DEB + 1) begin
              e_code = m_row * COLS + m_col;
              e_valid = 1; e_held = 1; m_elapsed = 0; m_mode = M_HELD;
            end
          end else begin
            m_row = (m_row + 1) % ROWS; m_dwell = 0; m_mode = M_SCAN;
          end
        end
        M_HELD: begin
          if (!csm[m_col]) begin
            m_run = 0; m_mode = M_REL;
          end else begin
            m_elapsed++;
            if (m_elapsed >= DLY && (m_elapsed - DLY) % RATE == 0) e_valid = 1;
          end
        end
        default: begin
          if (!csm[m_col]) begin
            m_run++;
            if (m_run == DEB + 1) begin
              e_rel = 1; e_held = 0;
              m_row = (m_row + 1) % ROWS; m_dwell = 0; m_mode = M_SCAN;
            end
          end else m_mode = M_HELD;
        end
      endcase
      s2 = s1;
      s1 = cin;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare of every output against the model, plus event log
  always @(negedge clk) begin
    if (m_started) begin
      chk("rows",        int'(rows),        1 << m_row);
      chk("key_code",    int'(key_code),    e_code);
      chk("key_valid",   int'(key_valid),   int'(e_valid));
      chk("key_held",    int'(key_held),    int'(e_held));
      chk("key_release", int'(key_release), int'(e_rel));
      chk("multi_key",   int'(multi_key),   int'(e_multi));
    end
    if (!reset) begin
      if (key_valid === 1'b1) begin n_valid++; vq.push_back(cyc); end
      if (key_release === 1'b1) n_rel++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int k = 0;
    do begin step(1); k++; end while (key_valid !== 1'b1 && k < budget);
    chk(nm, int'(key_valid === 1'b1), 1);
  endtask

  task automatic wait_rel(input int budget, input string nm);
    int k = 0;
    do begin step(1); k++; end while (key_release !== 1'b1 && k < budget);
    chk(nm, int'(key_release === 1'b1), 1);
  endtask

  initial begin
    int nv0, nr0, qi, k;
    // 1: reset, then idle scan
    reset = 1; keys = '0;
    step(3);
    chk("reset_rows", int'(rows), 1);
    chk("reset_held", int'(key_held), 0);
    reset = 0;
    step(3);
    chk("scan_row0_dwell", int'(rows), 4'b0001);
    step(1);
    chk("scan_row1_start", int'(rows), 4'b0010);
    step(60);
    chk("idle_no_valid", n_valid, 0);
    chk("idle_no_release", n_rel, 0);

    // 2: single key r1,c2
    nv0 = n_valid;
    keys[6] = 1'b1;
    wait_valid(200, "t2_valid_timeout");
    chk("t2_code", int'(key_code), 6);
    chk("t2_rows_frozen", int'(rows), 4'b0010);
    chk("t2_multi", int'(multi_key), 0);
    step(5);
    chk("t2_held", int'(key_held), 1);
    chk("t2_rows_still", int'(rows), 4'b0010);
    keys = '0;
    wait_rel(60, "t2_release_timeout");
    chk("t2_rows_after_rel", int'(rows), 4'b0100);
    chk("t2_one_valid", n_valid - nv0, 1);

    // 3: press glitch too short to accept
    k = 0;
    while (rows !== 4'b0001 && k < 50) begin step(1); k++; end
    while (rows === 4'b0001 && k < 60) begin step(1); k++; end
    chk("t3_align", int'(rows), 4'b0010);
    nv0 = n_valid;
    keys[6] = 1'b1;
    step(7);
    keys = '0;
    step(20);
    chk("t3_no_valid", n_valid - nv0, 0);
    chk("t3_not_held", int'(key_held), 0);

    // 4: release bounce
    keys[6] = 1'b1;
    wait_valid(200, "t4_valid_timeout");
    nv0 = n_valid; nr0 = n_rel;
    step(3);
    keys = '0;    step(3);
    keys[6] = 1'b1; step(3);
    chk("t4_still_held", int'(key_held), 1);
    keys = '0;
    wait_rel(60, "t4_release_timeout");
    step(5);
    chk("t4_no_extra_valid", n_valid - nv0, 0);
    chk("t4_one_release", n_rel - nr0, 1);

    // 5: two keys in row 3 with auto-repeat
    keys[13] = 1'b1; keys[15] = 1'b1;
    wait_valid(200, "t5_valid_timeout");
    qi = vq.size() - 1;
    chk("t5_code", int'(key_code), 13);
    chk("t5_multi", int'(multi_key), 1);
    step(100);
    chk("t5_repeat_count", vq.size() - qi - 1, 4);
    for (int i = 1; i <= 4; i++)
      if (qi + i < vq.size()) chk("t5_repeat_offset", vq[qi+i] - vq[qi], DLY + RATE*(i-1));
    keys = '0;
    wait_rel(60, "t5_release_timeout");
    chk("t5_multi_kept", int'(multi_key), 1);
    chk("t5_code_kept", int'(key_code), 13);

    // 6: reset while held
    keys[6] = 1'b1;
    wait_valid(200, "t6_valid_timeout");
    step(3);
    nr0 = n_rel;
    reset = 1;
    step(1);
    chk("t6_rows", int'(rows), 1);
    chk("t6_held", int'(key_held), 0);
    chk("t6_release", int'(key_release), 0);
    reset = 0; keys = '0;
    step(30);
    chk("t6_no_release", n_rel - nr0, 0);
    chk("t6_scanning", int'(key_held), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
